lsu_ctrl: RTL

//  Load/store unit on the CPU side of the Data_RAM port. Accepts one load/store request per handshake

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_ctrl_if.sv | 28 ++
 rtl/load_extend.sv | 28 ++
 rtl/lsu_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: RV32I width encodings and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned MEM_BYTES_DEFAULT = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    FAULT  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute-stage request/response signals plus the Data_RAM port of the load/store unit.
// Handshake: a request is taken on a rising edge where iReq=1 and oReady=1; iReq while oReady=0 is dropped, not queued.
interface lsu_ctrl_if;
  logic        iReq;
  logic        oReady;
  logic        iStore;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr;
  logic [31:0] iWrData;
  logic        oDone;
  logic        oFault;
  logic [31:0] oRdData;
  logic        oData_WrEn;
  logic [2:0]  oData_Funct3;
  logic [31:0] oData_Addr;
  logic [31:0] oData_WrData;
  logic [31:0] iData_RdData;

  modport slave (
    input  iReq, iStore, iFunct3, iAddr, iWrData, iData_RdData,
    output oReady, oDone, oFault, oRdData, oData_WrEn, oData_Funct3, oData_Addr, oData_WrData
  );

  modport master (
    output iReq, iStore, iFunct3, iAddr, iWrData, iData_RdData,
    input  oReady, oDone, oFault, oRdData, oData_WrEn, oData_Funct3, oData_Addr, oData_WrData
  );
endinterface

// File: rtl/load_extend.sv
// Picks the addressed byte/half-word out of a RAM word and sign- or zero-extends it by funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_word[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_word;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'd0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'd0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: registers one request, checks it, drives the RAM for one cycle and reports done/fault.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic       iClk,
  input  logic       iRst,
  lsu_ctrl_if.slave  bus,
  output lsu_state_e oState
);

  lsu_state_e  r_state;
  lsu_state_e  w_next;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wrdata;
  logic [31:0] r_rd_data;
  logic        w_accept;
  logic        w_misalign;
  logic        w_range;
  logic        w_illegal;
  logic        w_fault;
  logic        w_ready;
  logic        w_done;
  logic        w_fault_out;
  logic        w_wren;
  logic [31:0] w_ext;

  assign w_accept = (r_state == IDLE) && bus.iReq;

  // Checked on the live inputs so the FSM can branch to FAULT on the accepting edge.
  always_comb begin
    w_misalign = 1'b0;
    case (bus.iFunct3[1:0])
      2'b01:   w_misalign = bus.iAddr[0];
      2'b10:   w_misalign = |bus.iAddr[1:0];
      default: w_misalign = 1'b0;
    endcase
    w_range = bus.iAddr >= 32'(MEM_BYTES);
    if (bus.iStore)
      w_illegal = !(bus.iFunct3 inside {F3_B, F3_H, F3_W});
    else
      w_illegal = !(bus.iFunct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    w_fault = w_misalign | w_range | w_illegal;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    w_fault_out = 1'b0;
    w_wren      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.iReq) w_next = w_fault ? FAULT : ACCESS;
      end
      ACCESS: begin
        w_wren = r_store;
        w_next = RESP;
      end
      RESP: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      FAULT: begin
        w_done      = 1'b1;
        w_fault_out = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wrdata <= 32'd0;
    end else if (w_accept) begin
      r_store  <= bus.iStore;
      r_funct3 <= bus.iFunct3;
      r_addr   <= bus.iAddr;
      r_wrdata <= bus.iWrData;
    end
  end

  load_extend u_load_extend (
    .i_word   (bus.iData_RdData),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_ext)
  );

  // The RAM read is combinational, so the result is valid by the end of ACCESS.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)                               r_rd_data <= 32'd0;
    else if (r_state == ACCESS && !r_store) r_rd_data <= w_ext;
  end

  assign bus.oReady       = w_ready;
  assign bus.oDone        = w_done;
  assign bus.oFault       = w_fault_out;
  assign bus.oRdData      = r_rd_data;
  assign bus.oData_WrEn   = w_wren;
  assign bus.oData_Funct3 = r_funct3;
  assign bus.oData_Addr   = r_addr;
  assign bus.oData_WrData = r_wrdata;
  assign oState           = r_state;

endmodule
